// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: one outstanding request, answered exactly
// LATENCY cycles after acceptance with a one-cycle ack (err flags rejected requests).
module dmem_byte_lane #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    w_byte,
    output logic [7:0]    r_byte
);
    // Storage is deliberately left out of reset so contents survive rst_i.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we)
            mem[idx] <= w_byte;
    end

    assign r_byte = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] r_data_o
);
    localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic                       we;
        logic                       err;
        logic [AW-1:0]              idx;
        logic [NUM_LANES-1:0][7:0]  w_data;
        logic [NUM_LANES-1:0]       be;
    } req_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    req_t                      req_q, req_in;
    logic                      accept, commit;
    logic [31:0]               word_idx;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] rd_word;

    assign word_idx = {2'b00, addr_i[31:2]};

    // The error decision is taken at acceptance so later input changes cannot alter it.
    always_comb begin
        req_in.we     = we_i;
        req_in.err    = (addr_i[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS));
        req_in.idx    = addr_i[AW+1:2];
        req_in.w_data = w_data_i;
        req_in.be     = be_i;
    end

    assign accept = req_i && (state_q == IDLE);
    assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            req_q <= '0;
        else if (accept)
            req_q <= req_in;
    end

    // Read data only moves on read or error completions; write acks leave it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_data_o <= 32'd0;
        else if (commit) begin
            if (req_q.err)
                r_data_o <= 32'd0;
            else if (!req_q.we)
                r_data_o <= rd_word;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_we[g] = commit && req_q.we && !req_q.err && req_q.be[g];

        dmem_byte_lane #(
            .DEPTH (DEPTH_WORDS),
            .AW    (AW)
        ) u_lane (
            .clk_i  (clk_i),
            .we     (lane_we[g]),
            .idx    (req_q.idx),
            .w_byte (req_q.w_data[g]),
            .r_byte (rd_word[g])
        );
    end

    // ack/err decode straight from state so an async reset in RESP drops them at once.
    assign ready_o = (state_q == IDLE);
    assign ack_o   = (state_q == RESP);
    assign err_o   = (state_q == RESP) && req_q.err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, byte enables, errors, hold, reset cases.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, req_l1 = 1'b0, req_l15 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0, w_data = 32'd0;
    logic [3:0]  be = 4'd0;

    logic        ready, ack, err;
    logic [31:0] rdata;
    logic        ready_l1, ack_l1, err_l1;
    logic [31:0] rdata_l1;
    logic        ready_l15, ack_l15, err_l15;
    logic [31:0] rdata_l15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(3)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .w_data_i(w_data), .be_i(be), .ready_o(ready), .ack_o(ack),
        .err_o(err), .r_data_o(rdata));

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req_l1), .we_i(we), .addr_i(addr),
        .w_data_i(w_data), .be_i(be), .ready_o(ready_l1), .ack_o(ack_l1),
        .err_o(err_l1), .r_data_o(rdata_l1));

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(15)) u_dut_l15 (
        .clk_i(clk), .rst_i(rst), .req_i(req_l15), .we_i(we), .addr_i(addr),
        .w_data_i(w_data), .be_i(be), .ready_o(ready_l15), .ack_o(ack_l15),
        .err_o(err_l15), .r_data_o(rdata_l15));

    // One transaction on the main DUT; lat = edges from acceptance to the ack cycle.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic rdy, output int lat,
                        output logic e, output logic [31:0] rd, output int stray);
        @(negedge clk);
        rdy = ready;
        we = w; addr = a; w_data = d; be = b; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; w_data = 32'hA5A5_A5A5; be = 4'hF;
        lat = -1; e = 1'b0; rd = 32'd0; stray = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (err && !ack) stray++;
            if (ack) begin
                lat = i; e = err; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        xact(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_wr_ready got %0b want 1", rdy); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_wr_lat got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %0b want 0", e); end
        xact(1'b0, 32'h8, 32'h0, 4'h0, rdy, lat, e, rd, stray);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_rd_lat got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %0b want 0", e); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
        // A write ack must leave the last read data in place.
        xact(1'b1, 32'h20, 32'h12345678, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_wr_hold_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_enables();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        xact(1'b1, 32'h8, 32'h11223344, 4'b0101, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be_wr_err got %0b want 0", e); end
        xact(1'b0, 32'h8, 32'h0, 4'b0000, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_rd_data got %h want de22be44", rd); end
        xact(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be_zero_err got %0b want 0", e); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL be_zero_lat got %0d want 3", lat); end
        xact(1'b0, 32'h8, 32'h0, 4'b1111, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_rd got %h want de22be44", rd); end
    endtask

    task automatic test_errors();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        xact(1'b1, 32'h0, 32'h01020304, 4'hF, rdy, lat, e, rd, stray);
        xact(1'b0, 32'h0, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_pre_rd got %h want 01020304", rd); end
        xact(1'b0, 32'h6, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_misalign_err got %0b want 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_misalign_rdata got %h want 0", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL err_misalign_lat got %0d want 3", lat); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL err_without_ack got %0d want 0", stray); end
        xact(1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_range_wr got %0b want 1", e); end
        xact(1'b0, 32'h0, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_word0_err got %0b want 0", e); end
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_word0_rd got %h want 01020304", rd); end
        xact(1'b1, 32'h2, 32'hEEEEEEEE, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_misalign_wr got %0b want 1", e); end
        xact(1'b1, 32'h7C, 32'hA0B0C0D0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_last_word_wr got %0b want 0", e); end
        xact(1'b0, 32'h7C, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'hA0B0C0D0) begin errors++; $display("FAIL err_last_word_rd got %h want a0b0c0d0", rd); end
        xact(1'b0, 32'h0, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_misalign_wr_nochange got %h want 01020304", rd); end
    endtask

    task automatic test_hold_busy();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        logic [31:0] a_list [3];
        logic [31:0] d_list [3];
        int k, low_run, acks;
        a_list[0] = 32'h10; a_list[1] = 32'h14; a_list[2] = 32'h18;
        d_list[0] = 32'h1111_0010; d_list[1] = 32'h2222_0014; d_list[2] = 32'h3333_0018;
        for (int i = 0; i < 3; i++) xact(1'b1, a_list[i], d_list[i], 4'hF, rdy, lat, e, rd, stray);
        k = 0; low_run = 0; acks = 0;
        @(negedge clk);
        we = 1'b0; be = 4'hF;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (ack) begin
                acks++;
                checks++; if (rdata !== d_list[k-1]) begin errors++; $display("FAIL hold_rd%0d got %h want %h", k-1, rdata, d_list[k-1]); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_err%0d got %0b want 0", k-1, err); end
            end
            if (ready) begin
                if (k != 0) begin
                    checks++; if (low_run !== 4) begin errors++; $display("FAIL hold_ready_low got %0d want 4", low_run); end
                end
                low_run = 0;
                if (k == 3) begin
                    req = 1'b0;
                    break;
                end
                addr = a_list[k]; req = 1'b1; k++;
            end else begin
                low_run++;
                addr = 32'h0 + 32'(cyc % 2) * 32'h7C;
            end
        end
        req = 1'b0;
        checks++; if (acks !== 3) begin errors++; $display("FAIL hold_ack_count got %0d want 3", acks); end
    endtask

    task automatic test_reset_mid_op();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        int seen;
        xact(1'b1, 32'h4, 32'hCAFE0004, 4'hF, rdy, lat, e, rd, stray);
        xact(1'b0, 32'h4, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        @(negedge clk);
        we = 1'b1; addr = 32'h4; w_data = 32'h55; be = 4'hF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", ready); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %0b want 0", ack); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_ack got %0d want 0", seen); end
        xact(1'b0, 32'h4, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_after_ready got %0b want 1", rdy); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rstmid_after_lat got %0d want 3", lat); end
        checks++; if (rd !== 32'hCAFE0004) begin errors++; $display("FAIL rstmid_rd got %h want cafe0004", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic rdy, e; int lat, stray; logic [31:0] rd;
        int found;
        @(negedge clk);
        we = 1'b1; addr = 32'hC; w_data = 32'h0BADF00D; be = 4'hF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack) begin found = 1; break; end
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL rstresp_ack_timeout got %0d want 1", found); end
        rst = 1'b1;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstresp_ack_drop got %0b want 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstresp_err got %0b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'hC, 32'h0, 4'hF, rdy, lat, e, rd, stray);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rstresp_persist got %h want 0badf00d", rd); end
    endtask

    task automatic test_latency_sweep();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            checks++; if (ready_l1 !== 1'b1) begin errors++; $display("FAIL l1_ready%0d got %0b want 1", pass, ready_l1); end
            we = (pass == 0); addr = 32'h0; w_data = 32'h600DCAFE; be = 4'hF; req_l1 = 1'b1;
            @(posedge clk);
            #1 req_l1 = 1'b0;
            lat = -1;
            for (int i = 0; i <= 40; i++) begin
                @(negedge clk);
                if (ack_l1) begin
                    lat = i;
                    checks++; if (err_l1 !== 1'b0) begin errors++; $display("FAIL l1_err%0d got %0b want 0", pass, err_l1); end
                    if (pass == 1) begin
                        checks++; if (rdata_l1 !== 32'h600DCAFE) begin errors++; $display("FAIL l1_rd got %h want 600dcafe", rdata_l1); end
                    end
                    break;
                end
            end
            checks++; if (lat !== 1) begin errors++; $display("FAIL l1_lat%0d got %0d want 1", pass, lat); end
        end
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            checks++; if (ready_l15 !== 1'b1) begin errors++; $display("FAIL l15_ready%0d got %0b want 1", pass, ready_l15); end
            we = (pass == 0); addr = 32'h4; w_data = 32'hF00D0015; be = 4'hF; req_l15 = 1'b1;
            @(posedge clk);
            #1 req_l15 = 1'b0;
            lat = -1;
            for (int i = 0; i <= 40; i++) begin
                @(negedge clk);
                if (ack_l15) begin
                    lat = i;
                    checks++; if (err_l15 !== 1'b0) begin errors++; $display("FAIL l15_err%0d got %0b want 0", pass, err_l15); end
                    if (pass == 1) begin
                        checks++; if (rdata_l15 !== 32'hF00D0015) begin errors++; $display("FAIL l15_rd got %h want f00d0015", rdata_l15); end
                    end
                    break;
                end
            end
            checks++; if (lat !== 15) begin errors++; $display("FAIL l15_lat%0d got %0d want 15", pass, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enables();
        test_errors();
        test_hold_busy();
        test_reset_mid_op();
        test_reset_in_resp();
        test_latency_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH_WORDS, default 32: number of 32-bit storage words.
- LATENCY, default 3: cycles from request acceptance to response; legal range 1..15.

REQ-002 The block SHALL have these ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  1  request valid from the CPU-side initiator.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- w_data_i  in  32  write data.
- be_i  in  4  byte enables for writes; be_i[0] selects bits 7:0.
- ready_o  out  1  block can accept a request this cycle.
- ack_o  out  1  one-cycle response pulse.
- err_o  out  1  qualifies ack_o; the request was rejected.
- r_data_o  out  32  read data, valid when ack_o=1 and we=0.

Function
REQ-003 The block SHALL implement three states: IDLE, BUSY and RESP.
REQ-004 ready_o SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a rising edge where req_i=1 and ready_o=1. On acceptance the block SHALL:
- capture we_i, addr_i, w_data_i and be_i;
- load the latency counter with LATENCY-1;
- move to BUSY.
REQ-006 When req_i=1 while ready_o=0, the request SHALL be ignored. The initiator holds the request until it is accepted.
REQ-007 In BUSY the counter SHALL decrement by 1 per cycle. On the edge where the counter is 0, the block SHALL perform the access and enter RESP. Consequence: ack_o is high in the cycle beginning exactly LATENCY edges after the acceptance edge.
REQ-008 In RESP, ack_o SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE. ready_o SHALL therefore be 1 again in the cycle after the ack cycle, and back-to-back requests are separated by at least LATENCY+1 cycles.
REQ-009 Word index SHALL be addr[31:2]. A request SHALL be an error if addr[1:0] != 0 or if the word index >= DEPTH_WORDS.
REQ-010 For an error request:
- err_o=1 with ack_o;
- no storage change;
- r_data_o is driven to 0.
REQ-011 A valid write SHALL update only the bytes whose be_i bit is 1. be_i=0000 is legal: no change, acked with err_o=0.
REQ-012 A valid read SHALL load r_data_o with the full stored word, ignoring be_i.
REQ-013 r_data_o SHALL hold its value until the next read or error ack. Write acks SHALL NOT change it.
REQ-014 err_o SHALL be 0 whenever ack_o=0.
REQ-015 At most one request SHALL be outstanding. A read following a write to the same word SHALL return the written data.
REQ-016 Input changes after acceptance SHALL have no effect on the in-flight access.

Reset
REQ-017 Reset values while rst_i=1 SHALL be: state=IDLE, counter=0, ready_o=1, ack_o=0, err_o=0, r_data_o=0.
REQ-018 Reset SHALL NOT clear storage contents.
REQ-019 Reset asserted in BUSY SHALL abort the access:
- no storage write;
- no ack.
REQ-020 Reset asserted in RESP SHALL drop ack_o to 0 immediately (asynchronously). A write already committed on the BUSY->RESP edge SHALL persist.
REQ-021 After rst_i deasserts, the first accepted request SHALL behave per REQ-005..REQ-013.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (LATENCY=3 unless stated):
- Basic write/read: write addr=0x8, data=0xDEADBEEF, be=1111, then read addr=0x8 -> ack 3 cycles after each acceptance; r_data_o=0xDEADBEEF; err_o=0.
- Byte enables: word 0x8 = 0xDEADBEEF, write 0x11223344 with be=0101, read back -> r_data_o=0xDE22BE44.
- Errors: read addr=0x6 -> err_o=1, r_data_o=0. Write addr=0x80 (DEPTH 32) -> err_o=1, and a subsequent read of word 0 is unchanged.
- Hold during BUSY: req_i held high continuously with changing addr -> exactly one ack per accepted request; ready_o low for 4 cycles per request; captured addr is used.
- Reset mid-operation: accept write 0x55 to addr=0x4, assert rst_i one cycle later -> no ack; after reset, read of addr=0x4 returns the prior contents; ready_o=1 during reset.
- Latency sweep: LATENCY=1 and LATENCY=15, a single read each -> ack exactly 1 and 15 cycles after acceptance.
